// File: rtl/upe_serial_rx64_if.sv
// upe_serial_rx64_if
//   Bundles the serial input line and the parallel output handshake of the
//   UPE serial receiver.
//   Signals:
//     ser_in     serial line into the receiver (idle low)
//     out_ready  consumer accepts out_data while out_valid is high
//     out_data   last good received word, bit 0 first on the line
//     out_valid  out_data holds an unconsumed word
//     frame_err  one-cycle pulse, stop bit was high
//     overrun    one-cycle pulse, good word dropped because the previous one was unconsumed
//     busy       receiver is inside a frame
//   Modports: master = receiver side, slave = line driver / consumer side.
interface upe_serial_rx64_if #(
    parameter int unsigned WIDTH = 64
);
    logic             ser_in;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        input  ser_in,
        input  out_ready,
        output out_data,
        output out_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output ser_in,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/upe_serial_rx64.sv
// upe_serial_rx64
//   Serial-to-parallel receiver for 64-bit UPE operands. Accepts a framed,
//   LSB-first bit stream (start high, WIDTH data bits, stop low) with a fixed
//   BIT_TICKS clock cycles per bit, and hands the word out on a valid/ready
//   handshake.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    upe_serial_rx64_if.master (ser_in, out_ready in; out_data,
//            out_valid, frame_err, overrun, busy out)
module upe_serial_rx64 #(
    parameter int unsigned BIT_TICKS = 1252,
    parameter int unsigned WIDTH     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    upe_serial_rx64_if.master bus
);
    localparam int unsigned   CW       = $clog2(BIT_TICKS);
    localparam int unsigned   IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // The counter expires when it reads zero, so loads are one less than
    // the wanted spacing; this keeps BIT_TICKS-1 inside clog2(BIT_TICKS) bits.
    localparam logic [CW-1:0] HALF_LD  = CW'(BIT_TICKS / 2 - 1);
    localparam logic [CW-1:0] BIT_LD   = CW'(BIT_TICKS - 1);
    localparam logic [6:0]    LAST_IDX = 7'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state, state_n;
    logic             sync1, s, s_d;
    logic [CW-1:0]    cnt, cnt_n;
    logic [6:0]       idx, idx_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] data_q;
    logic             valid_q, ferr_q, ovr_q;
    logic             load, ferr_n, ovr_n, expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        load    = 1'b0;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        expire  = (cnt == '0);

        if (state != IDLE && !expire) cnt_n = cnt - 1'b1;

        case (state)
            IDLE: begin
                if (s && !s_d) begin
                    state_n = START;
                    cnt_n   = HALF_LD;
                end
            end
            START: begin
                if (expire) begin
                    if (s) begin
                        state_n = DATA;
                        cnt_n   = BIT_LD;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_n[idx[IW-1:0]] = s;
                    cnt_n = BIT_LD;
                    if (idx == LAST_IDX) state_n = STOP;
                    else                 idx_n   = idx + 1'b1;
                end
            end
            STOP: begin
                if (expire) begin
                    state_n = IDLE;
                    if (s)                              ferr_n = 1'b1;
                    else if (!valid_q || bus.out_ready) load   = 1'b1;
                    else                                ovr_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1  <= bus.ser_in;
            s      <= sync1;
            s_d    <= s;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            ferr_q <= ferr_n;
            ovr_q  <= ovr_n;
            // A load in the same cycle as an accept keeps valid high.
            if (load) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = (state != IDLE);
endmodule
